// File: rtl/alu_seq.sv
// Multi-cycle WIDTH-bit ALU with a valid/ready handshake on both sides.
// Optional iterative MUL/DIV datapath is enabled by defining ALU_MULDIV_EN.
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             zero,
    output logic             div_by_zero
);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_MUL  = 4'd2;
    localparam logic [3:0] OP_DIV  = 4'd3;
    localparam logic [3:0] OP_SHL  = 4'd4;
    localparam logic [3:0] OP_SHR  = 4'd5;
    localparam logic [3:0] OP_ROL  = 4'd6;
    localparam logic [3:0] OP_ROR  = 4'd7;
    localparam logic [3:0] OP_AND  = 4'd8;
    localparam logic [3:0] OP_OR   = 4'd9;
    localparam logic [3:0] OP_XOR  = 4'd10;
    localparam logic [3:0] OP_NOR  = 4'd11;
    localparam logic [3:0] OP_NAND = 4'd12;
    localparam logic [3:0] OP_XNOR = 4'd13;
    localparam logic [3:0] OP_LT   = 4'd14;
    localparam logic [3:0] OP_EQ   = 4'd15;

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Returns {carry, result} for every op that finishes in the accept cycle.
    function automatic logic [WIDTH:0] alu_single(input logic [3:0]       op,
                                                  input logic [WIDTH-1:0] x,
                                                  input logic [WIDTH-1:0] y);
        logic [WIDTH:0] r;
        r = '0;
        case (op)
            OP_ADD:  r = {1'b0, x} + {1'b0, y};
            OP_SUB:  r = {(x < y), x - y};
            OP_MUL:  r = '0;
`ifdef ALU_MULDIV_EN
            OP_DIV:  r = {1'b0, {WIDTH{1'b1}}};
`else
            OP_DIV:  r = '0;
`endif
            OP_SHL:  r = {x[WIDTH-1], x[WIDTH-2:0], 1'b0};
            OP_SHR:  r = {x[0], 1'b0, x[WIDTH-1:1]};
            OP_ROL:  r = {1'b0, x[WIDTH-2:0], x[WIDTH-1]};
            OP_ROR:  r = {1'b0, x[0], x[WIDTH-1:1]};
            OP_AND:  r = {1'b0, x & y};
            OP_OR:   r = {1'b0, x | y};
            OP_XOR:  r = {1'b0, x ^ y};
            OP_NOR:  r = {1'b0, ~(x | y)};
            OP_NAND: r = {1'b0, ~(x & y)};
            OP_XNOR: r = {1'b0, ~(x ^ y)};
            OP_LT:   r = {1'b0, {(WIDTH-1){1'b0}}, (x < y)};
            OP_EQ:   r = {1'b0, {(WIDTH-1){1'b0}}, (x == y)};
            default: r = '0;
        endcase
        return r;
    endfunction

    logic             accept;
    logic             start_iter;
    logic             iter_last;
    logic             dbz_d;
    logic [WIDTH:0]   single_res;

    assign accept     = (state_q == IDLE) && in_valid;
    assign single_res = alu_single(sel, a, b);
    assign in_ready   = (state_q == IDLE);
    assign out_valid  = (state_q == DONE);

`ifdef ALU_MULDIV_EN
    logic [WIDTH-1:0] a_q, b_q, hi_q, lo_q;
    logic [CNT_W-1:0] cnt_q;
    logic             is_div_q;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_hi_n, mul_lo_n;
    logic [WIDTH:0]   rem_sh;
    logic             div_borrow;
    logic [WIDTH-1:0] div_hi_n, div_lo_n;
    logic [WIDTH-1:0] hi_n, lo_n;

    assign start_iter = (sel == OP_MUL) || ((sel == OP_DIV) && (b != '0));
    assign iter_last  = (cnt_q == CNT_W'(WIDTH - 1));
    assign dbz_d      = (sel == OP_DIV) && (b == '0);

    // Shift-add multiply: {hi,lo} starts as {0,b}, adds a into hi when lo[0] set, shifts right.
    always_comb begin
        mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : '0);
        mul_hi_n = mul_sum[WIDTH:1];
        mul_lo_n = {mul_sum[0], lo_q[WIDTH-1:1]};
    end

    // Restoring divide: hi holds the remainder, lo shifts dividend out and quotient in.
    always_comb begin
        rem_sh     = {hi_q, lo_q[WIDTH-1]};
        div_borrow = (rem_sh < {1'b0, b_q});
        if (div_borrow) begin
            div_hi_n = rem_sh[WIDTH-1:0];
            div_lo_n = {lo_q[WIDTH-2:0], 1'b0};
        end else begin
            div_hi_n = rem_sh[WIDTH-1:0] - b_q;
            div_lo_n = {lo_q[WIDTH-2:0], 1'b1};
        end
    end

    assign hi_n = is_div_q ? div_hi_n : mul_hi_n;
    assign lo_n = is_div_q ? div_lo_n : mul_lo_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q      <= '0;
            b_q      <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
        end else if (accept && start_iter) begin
            a_q      <= a;
            b_q      <= b;
            hi_q     <= '0;
            lo_q     <= (sel == OP_DIV) ? a : b;
            cnt_q    <= '0;
            is_div_q <= (sel == OP_DIV);
        end else if (state_q == BUSY) begin
            hi_q  <= hi_n;
            lo_q  <= lo_n;
            cnt_q <= cnt_q + 1'b1;
        end
    end
`else
    assign start_iter = 1'b0;
    assign iter_last  = 1'b1;
    assign dbz_d      = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = start_iter ? BUSY : DONE;
            BUSY:    if (iter_last) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Output register: loaded once per op, held through DONE until transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result      <= '0;
            carry_out   <= 1'b0;
            zero        <= 1'b0;
            div_by_zero <= 1'b0;
        end else if (accept && !start_iter) begin
            result      <= single_res[WIDTH-1:0];
            carry_out   <= single_res[WIDTH];
            zero        <= (single_res[WIDTH-1:0] == '0);
            div_by_zero <= dbz_d;
        end
`ifdef ALU_MULDIV_EN
        else if ((state_q == BUSY) && iter_last) begin
            result      <= lo_n;
            carry_out   <= is_div_q ? 1'b0 : (mul_hi_n != '0);
            zero        <= (lo_n == '0);
            div_by_zero <= 1'b0;
        end
`endif
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed scoreboard bench for alu_seq at WIDTH=8; expectations follow ALU_MULDIV_EN.
module tb_alu_seq;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [3:0]   sel = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] result;
    logic         carry_out;
    logic         zero;
    logic         div_by_zero;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [W-1:0] res;
        logic         c;
        logic         dbz;
    } exp_t;

    exp_t sb[$];

    alu_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sel(sel),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .carry_out(carry_out),
        .zero(zero), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [3:0] s, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t e;
        int unsigned xi, yi, t;
        xi = x;
        yi = y;
        e  = '0;
        case (s)
            4'd0:  begin t = xi + yi; e.res = t[W-1:0]; e.c = (t > 255); end
            4'd1:  begin t = (xi - yi) & 32'hFF; e.res = t[W-1:0]; e.c = (xi < yi); end
`ifdef ALU_MULDIV_EN
            4'd2:  begin t = xi * yi; e.res = t[W-1:0]; e.c = (t > 255); end
            4'd3:  begin
                       if (yi == 0) begin e.res = 8'hFF; e.dbz = 1'b1; end
                       else begin t = xi / yi; e.res = t[W-1:0]; end
                   end
`else
            4'd2, 4'd3: e = '0;
`endif
            4'd4:  begin t = (xi * 2) & 32'hFF; e.res = t[W-1:0]; e.c = (xi >= 128); end
            4'd5:  begin t = xi / 2; e.res = t[W-1:0]; e.c = (xi % 2 == 1); end
            4'd6:  begin t = ((xi * 2) & 32'hFF) + (xi / 128); e.res = t[W-1:0]; end
            4'd7:  begin t = (xi / 2) + ((xi % 2) * 128); e.res = t[W-1:0]; end
            4'd8:  e.res = x & y;
            4'd9:  e.res = x | y;
            4'd10: e.res = x ^ y;
            4'd11: e.res = ~(x | y);
            4'd12: e.res = ~(x & y);
            4'd13: e.res = ~(x ^ y);
            4'd14: e.res = (xi < yi) ? 8'd1 : 8'd0;
            4'd15: e.res = (xi == yi) ? 8'd1 : 8'd0;
            default: e = '0;
        endcase
        return e;
    endfunction

    function automatic int exp_latency(input logic [3:0] s, input logic [W-1:0] y);
`ifdef ALU_MULDIV_EN
        if (s == 4'd2 || (s == 4'd3 && y != 0)) return W + 1;
`endif
        return 1;
    endfunction

    task automatic run_op(input string tag, input logic [3:0] s, input logic [W-1:0] x,
                          input logic [W-1:0] y, input int hold);
        exp_t         e;
        int           lat;
        logic [W-1:0] r0;
        sb.push_back(model(s, x, y));
        check({tag, ".in_ready_idle"}, in_ready, 1);
        in_valid  = 1'b1;
        a         = x;
        b         = y;
        sel       = s;
        out_ready = 1'b0;
        @(posedge clk); #1;
        // garbage inputs with in_valid held high must be ignored until IDLE
        a   = W'($urandom);
        b   = W'($urandom);
        sel = 4'($urandom);
        lat = 1;
        while (out_valid !== 1'b1 && lat < 64) begin
            check({tag, ".in_ready_busy"}, in_ready, 0);
            @(posedge clk); #1;
            lat++;
        end
        check({tag, ".latency"}, lat, exp_latency(s, y));
        r0 = result;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check({tag, ".hold_valid"}, out_valid, 1);
            check({tag, ".hold_in_ready"}, in_ready, 0);
            check({tag, ".hold_result"}, result, r0);
        end
        if (sb.size() == 0) begin
            check({tag, ".sb_empty"}, 0, 1);
        end else begin
            e = sb.pop_front();
            check({tag, ".result"}, result, e.res);
            check({tag, ".carry"}, carry_out, e.c);
            check({tag, ".zero"}, zero, (e.res == '0));
            check({tag, ".dbz"}, div_by_zero, e.dbz);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check({tag, ".post_valid"}, out_valid, 0);
        check({tag, ".post_in_ready"}, in_ready, 1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, ".in_ready"}, in_ready, 1);
        check({tag, ".out_valid"}, out_valid, 0);
        check({tag, ".result"}, result, 0);
        check({tag, ".carry"}, carry_out, 0);
        check({tag, ".zero"}, zero, 0);
        check({tag, ".dbz"}, div_by_zero, 0);
    endtask

    initial begin
        #1;
        check_reset_values("reset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // out_ready while idle has no effect
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("idle_out_ready.valid", out_valid, 0);
        check("idle_out_ready.in_ready", in_ready, 1);
        out_ready = 1'b0;

        run_op("add_200_100", 4'd0, 8'd200, 8'd100, 0);
        run_op("add_255_1",   4'd0, 8'd255, 8'd1,   0);
        run_op("sub_5_5",     4'd1, 8'd5,   8'd5,   0);
        run_op("sub_3_4",     4'd1, 8'd3,   8'd4,   0);
        run_op("mul_20_13",   4'd2, 8'd20,  8'd13,  0);
        run_op("mul_255_255", 4'd2, 8'd255, 8'd255, 0);
        run_op("mul_15_17",   4'd2, 8'd15,  8'd17,  0);
        run_op("div_200_7",   4'd3, 8'd200, 8'd7,   0);
        run_op("div_255_255", 4'd3, 8'd255, 8'd255, 0);
        run_op("div_7_200",   4'd3, 8'd7,   8'd200, 0);
        run_op("div_9_0",     4'd3, 8'd9,   8'd0,   0);
        run_op("rol_81_hold", 4'd6, 8'h81,  8'h00,  5);
        run_op("shl_81",      4'd4, 8'h81,  8'h00,  0);
        run_op("shr_81",      4'd5, 8'h81,  8'h00,  0);
        run_op("ror_81",      4'd7, 8'h81,  8'h00,  0);
        run_op("and",         4'd8, 8'hCA,  8'h5C,  0);
        run_op("or",          4'd9, 8'hCA,  8'h5C,  0);
        run_op("xor",         4'd10, 8'hCA, 8'h5C,  0);
        run_op("nor",         4'd11, 8'hCA, 8'h5C,  0);
        run_op("nand",        4'd12, 8'hCA, 8'h5C,  0);
        run_op("xnor",        4'd13, 8'hCA, 8'h5C,  0);
        run_op("lt_3_4",      4'd14, 8'd3,  8'd4,   0);
        run_op("lt_4_3",      4'd14, 8'd4,  8'd3,   0);
        run_op("eq_7_7",      4'd15, 8'd7,  8'd7,   0);
        run_op("eq_7_8",      4'd15, 8'd7,  8'd8,   1);

        for (int i = 0; i < 24; i++) begin
            run_op("rand", 4'($urandom_range(0, 15)), W'($urandom), W'($urandom),
                   $urandom_range(0, 2));
        end

        // Reset in the middle of a MUL (or while it sits in DONE)
        check("rst_mid.in_ready", in_ready, 1);
        in_valid  = 1'b1;
        a         = 8'd20;
        b         = 8'd13;
        sel       = 4'd2;
        out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_reset_values("rst_mid");
        @(posedge clk); #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            check("rst_mid.no_pulse", out_valid, 0);
        end
        out_ready = 1'b0;
        run_op("add_1_1_after_rst", 4'd0, 8'd1, 8'd1, 0);
        check("sb_drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
